// File: rtl/racket_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : racket_ctrl
//  Purpose  : Sequences one racket's movement. Arbitrates between player
//             buttons and a ball-tracking CPU driver, paces moves with a
//             tick divider and enforces top/bottom screen limits.
//  Revision : 1.0  initial release
// ============================================================================
module racket_ctrl #(
    parameter int TICK_DIV     = 4,
    parameter int SCREEN_H     = 480,
    parameter int RACKET_H     = 80,
    parameter int DEADBAND     = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       cpu_en,
    input  logic       freeze,
    input  logic [9:0] ball_y,
    input  logic [9:0] racket_y,
    output logic       move_up,
    output logic       move_down,
    output logic [1:0] mode,
    output logic       tick
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [10:0]       HALF_H    = 11'(RACKET_H / 2);
    localparam logic [10:0]       DEAD      = 11'(DEADBAND);
    localparam logic [9:0]        Y_BOTTOM  = 10'(SCREEN_H - RACKET_H);

    typedef enum logic [1:0] {
        ST_FROZEN = 2'b00,
        ST_HUMAN  = 2'b01,
        ST_CPU    = 2'b10
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [IDLE_W-1:0]   idle_cnt;

    logic                any_btn;
    logic                fire;
    logic [10:0]         center;
    logic [10:0]         ball_ext;
    logic                cpu_up;
    logic                cpu_dn;
    logic                cmd_up;
    logic                cmd_dn;
    logic                at_top;
    logic                at_bottom;

    assign any_btn   = btn_up | btn_down;
    assign tick      = (tick_cnt == TICK_LAST);
    // A freeze on the tick cycle cancels that tick's strobe.
    assign fire      = tick & ~freeze;
    assign mode      = state;

    // CPU tracking in 11 bits so center and deadband sums cannot wrap.
    assign center    = {1'b0, racket_y} + HALF_H;
    assign ball_ext  = {1'b0, ball_y};
    assign cpu_up    = (ball_ext + DEAD) < center;
    assign cpu_dn    = ball_ext > (center + DEAD);

    assign at_top    = (racket_y == 10'd0);
    assign at_bottom = (racket_y >= Y_BOTTOM);

    // Select the move command from the current source; FROZEN never moves.
    always_comb begin
        cmd_up = 1'b0;
        cmd_dn = 1'b0;
        case (state)
            ST_HUMAN: begin
                cmd_up = btn_up & ~btn_down;
                cmd_dn = btn_down & ~btn_up;
            end
            ST_CPU: begin
                cmd_up = cpu_up;
                cmd_dn = cpu_dn;
            end
            default: begin
                cmd_up = 1'b0;
                cmd_dn = 1'b0;
            end
        endcase
    end

    // Free-running move pacing counter, independent of mode changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Mode FSM, idle timeout counter and registered move strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_FROZEN;
            idle_cnt  <= '0;
            move_up   <= 1'b0;
            move_down <= 1'b0;
        end else begin
            // Strobes: one cycle after a tick, gated by the screen limits.
            move_up   <= fire & cmd_up & ~at_top;
            move_down <= fire & cmd_dn & ~at_bottom;

            if (freeze) begin
                state <= ST_FROZEN;
            end else begin
                case (state)
                    ST_FROZEN: state <= ST_HUMAN;
                    ST_HUMAN: begin
                        if (cpu_en && (idle_cnt == IDLE_MAX) && !any_btn) begin
                            state <= ST_CPU;
                        end
                    end
                    ST_CPU: begin
                        if (any_btn || !cpu_en) begin
                            state <= ST_HUMAN;
                        end
                    end
                    default: state <= ST_FROZEN;
                endcase
            end

            // Idle counter restarts on any button or on entry to HUMAN;
            // otherwise counts button-free human ticks up to the timeout.
            if (any_btn
                || (!freeze && (state == ST_FROZEN))
                || (!freeze && (state == ST_CPU) && !cpu_en)) begin
                idle_cnt <= '0;
            end else if ((state == ST_HUMAN) && fire && (idle_cnt != IDLE_MAX)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_racket_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_racket_ctrl
//  Purpose  : Directed self-checking bench for racket_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_racket_ctrl;

    localparam int TICK_DIV = 4;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       cpu_en;
    logic       freeze;
    logic [9:0] ball_y;
    logic [9:0] racket_y;
    logic       move_up;
    logic       move_down;
    logic [1:0] mode;
    logic       tick;

    int total;
    int bad;

    racket_ctrl #(
        .TICK_DIV     (TICK_DIV),
        .SCREEN_H     (480),
        .RACKET_H     (80),
        .DEADBAND     (4),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .cpu_en    (cpu_en),
        .freeze    (freeze),
        .ball_y    (ball_y),
        .racket_y  (racket_y),
        .move_up   (move_up),
        .move_down (move_down),
        .mode      (mode),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watch n cycles, sampling at falling edges; tallies strobes and ticks.
    task automatic count_window(input int n, output int ups, output int dns,
                                output int ticks, output int gap_bad);
        int last_u;
        int last_d;
        ups = 0; dns = 0; ticks = 0; gap_bad = 0;
        last_u = -1; last_d = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tick) ticks++;
            if (move_up && move_down) gap_bad++;
            if (move_up) begin
                if (last_u >= 0 && (i - last_u) != TICK_DIV) gap_bad++;
                last_u = i;
                ups++;
            end
            if (move_down) begin
                if (last_d >= 0 && (i - last_d) != TICK_DIV) gap_bad++;
                last_d = i;
                dns++;
            end
        end
    endtask

    task automatic test_reset();
        bit found;
        total++; if (mode !== 2'b00) begin bad++; $display("FAIL reset_mode: got %0d want 0", mode); end
        total++; if (move_up !== 1'b0 || move_down !== 1'b0) begin bad++; $display("FAIL reset_moves: got up=%0b dn=%0b want 0 0", move_up, move_down); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0b want 0", tick); end
        reset = 1'b1;
        #1;
        total++; if (mode !== 2'b00) begin bad++; $display("FAIL release_mode_early: got %0d want 0", mode); end
        @(negedge clk);
        total++; if (mode !== 2'b01) begin bad++; $display("FAIL release_mode: got %0d want 1", mode); end
        // Catch a move_up pulse and reset in the middle of it.
        racket_y = 10'd200;
        btn_up   = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (move_up) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL reset_pulse_wait: got no move_up want pulse within 8 cycles"); end
        reset = 1'b0;
        #1;
        total++; if (move_up !== 1'b0 || mode !== 2'b00 || tick !== 1'b0) begin
            bad++; $display("FAIL reset_mid_pulse: got up=%0b mode=%0d tick=%0b want 0 0 0", move_up, mode, tick);
        end
        @(negedge clk);
        reset  = 1'b1;
        btn_up = 1'b0;
        @(negedge clk);
        total++; if (mode !== 2'b01) begin bad++; $display("FAIL rerelease_mode: got %0d want 1", mode); end
    endtask

    task automatic test_human_up();
        int u, d, t, g;
        racket_y = 10'd200;
        btn_up   = 1'b1;
        count_window(40, u, d, t, g);
        btn_up = 1'b0;
        total++; if (u != 10) begin bad++; $display("FAIL human_up_count: got %0d want 10", u); end
        total++; if (d != 0)  begin bad++; $display("FAIL human_up_no_down: got %0d want 0", d); end
        total++; if (g != 0)  begin bad++; $display("FAIL human_up_spacing: got %0d bad gaps want 0", g); end
        total++; if (t != 10) begin bad++; $display("FAIL tick_count: got %0d want 10", t); end
    endtask

    task automatic test_conflict_limit();
        int u, d, t, g;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        count_window(40, u, d, t, g);
        total++; if (u + d != 0) begin bad++; $display("FAIL conflict_pulses: got %0d want 0", u + d); end
        btn_down = 1'b0;
        racket_y = 10'd0;
        count_window(40, u, d, t, g);
        total++; if (u + d != 0) begin bad++; $display("FAIL top_limit_pulses: got %0d want 0", u + d); end
        total++; if (mode !== 2'b01) begin bad++; $display("FAIL top_limit_mode: got %0d want 1", mode); end
        btn_up   = 1'b0;
        racket_y = 10'd200;
    endtask

    task automatic test_cpu_takeover();
        int u, d, t, g;
        int tbl_ball [7] = '{100, 238, 236, 235, 244, 245, 300};
        int tbl_up   [7] = '{10,  0,   0,   10,  0,   0,   0};
        int tbl_dn   [7] = '{0,   0,   0,   0,   0,   10,  10};
        cpu_en = 1'b1;
        ball_y = 10'd238;
        count_window(56, u, d, t, g);
        total++; if (mode !== 2'b01) begin bad++; $display("FAIL takeover_early: got %0d want 1", mode); end
        count_window(12, u, d, t, g);
        total++; if (mode !== 2'b10) begin bad++; $display("FAIL takeover_mode: got %0d want 2", mode); end
        for (int k = 0; k < 7; k++) begin
            ball_y = 10'(tbl_ball[k]);
            count_window(40, u, d, t, g);
            total++; if (u != tbl_up[k] || d != tbl_dn[k] || mode !== 2'b10) begin
                bad++; $display("FAIL cpu_track ball=%0d: got up=%0d dn=%0d mode=%0d want up=%0d dn=%0d mode=2",
                                tbl_ball[k], u, d, mode, tbl_up[k], tbl_dn[k]);
            end
        end
    endtask

    task automatic test_override_freeze();
        int u, d, t, g;
        bit found;
        ball_y   = 10'd238;
        btn_down = 1'b1;
        @(negedge clk);
        btn_down = 1'b0;
        total++; if (mode !== 2'b01) begin bad++; $display("FAIL override_mode: got %0d want 1", mode); end
        // A cleared idle counter keeps HUMAN for 10 button-free ticks.
        count_window(40, u, d, t, g);
        total++; if (mode !== 2'b01 || u + d != 0) begin
            bad++; $display("FAIL override_idle_cleared: got mode=%0d pulses=%0d want 1 0", mode, u + d);
        end
        btn_up = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (tick) found = 1'b1;
            else @(negedge clk);
        end
        total++; if (!found) begin bad++; $display("FAIL freeze_tick_wait: got no tick want tick within 8 cycles"); end
        freeze = 1'b1;
        @(negedge clk);
        total++; if (move_up !== 1'b0 || mode !== 2'b00) begin
            bad++; $display("FAIL freeze_on_tick: got up=%0b mode=%0d want 0 0", move_up, mode);
        end
        count_window(40, u, d, t, g);
        total++; if (u + d != 0 || mode !== 2'b00) begin
            bad++; $display("FAIL frozen_quiet: got pulses=%0d mode=%0d want 0 0", u + d, mode);
        end
        freeze = 1'b0;
        btn_up = 1'b0;
        @(negedge clk);
        total++; if (mode !== 2'b01) begin bad++; $display("FAIL unfreeze_mode: got %0d want 1", mode); end
    endtask

    task automatic test_bottom_limit();
        int u, d, t, g;
        bit found;
        cpu_en   = 1'b1;
        racket_y = 10'd400;
        ball_y   = 10'd479;
        count_window(68, u, d, t, g);
        total++; if (mode !== 2'b10) begin bad++; $display("FAIL bottom_cpu_mode: got %0d want 2", mode); end
        count_window(40, u, d, t, g);
        total++; if (d != 0) begin bad++; $display("FAIL bottom_limit: got %0d move_down want 0", d); end
        racket_y = 10'd399;
        found    = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (move_down) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL bottom_release: got no move_down want pulse within 4 cycles"); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cpu_en   = 1'b0;
        freeze   = 1'b0;
        ball_y   = 10'd0;
        racket_y = 10'd200;
        repeat (2) @(negedge clk);
        test_reset();
        test_human_up();
        test_conflict_limit();
        test_cpu_takeover();
        test_override_freeze();
        test_bottom_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
